// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a program image as a byte stream and writes it
// into the instruction memory as aligned little-endian 32-bit words.
//
// Stream: LEN_LO, LEN_HI (16-bit payload length L in bytes), then L bytes.
// With INSTR_LOADER_CHECKSUM_EN defined, one further byte must equal the
// XOR of all payload bytes, or the load ends in error.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          begin a session (honoured only in IDLE/DONE/ERR)
//   byte_i/byte_valid_i/byte_ready_o   byte stream handshake
//   wr_en_o/wr_addr_o/wr_data_o        instruction memory write port
//   busy_o           session in progress (holds the CPU)
//   done_o, err_o    level status of the last session
module instr_mem_loader #(
  parameter int MEM_SIZE = 4096,
  parameter int ADDR_W   = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [16:0] MEM_LIM = 17'(MEM_SIZE);

  state_t            state, nxt;
  logic [15:0]       len;
  logic [ADDR_W:0]   bcnt;   // payload bytes accepted so far
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wbuf;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        len_zero, len_bad, last_word;

  assign accept    = byte_valid_i && byte_ready_o;
  assign len_full  = {byte_i, len[7:0]};
  assign len_zero  = (len_full == 16'd0);
  assign len_bad   = ({1'b0, len_full} > MEM_LIM) || (len_full[1:0] != 2'b00);
  assign last_word = (17'(bcnt) == {1'b0, len});

  assign wr_addr_o = addr;
  assign wr_data_o = wbuf;

  always_comb begin
    nxt          = state;
    byte_ready_o = 1'b0;
    wr_en_o      = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready_o = 1'b1;
        if (accept) nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready_o = 1'b1;
        if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (len_zero)     nxt = S_CSUM;
`else
          if (len_zero)     nxt = S_DONE;
`endif
          else if (len_bad) nxt = S_ERR;
          else              nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready_o = 1'b1;
        if (accept && bcnt[1:0] == 2'd3) nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en_o = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        nxt = last_word ? S_CSUM : S_DATA;
`else
        nxt = last_word ? S_DONE : S_DATA;
`endif
      end
      S_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        if (start_i) nxt = S_LEN_LO;
      end
      S_ERR: begin
        busy_o = 1'b0;
        err_o  = 1'b1;
        if (start_i) nxt = S_LEN_LO;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready_o = 1'b1;
        if (accept) nxt = (byte_i == csum) ? S_DONE : S_ERR;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      len   <= '0;
      bcnt  <= '0;
      addr  <= '0;
      wbuf  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      state <= nxt;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            len  <= '0;
            bcnt <= '0;
            addr <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        S_LEN_LO: if (accept) len[7:0] <= byte_i;
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_i;
            bcnt      <= '0;
            addr      <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            // little-endian: byte index mod 4 selects the lane
            wbuf[{bcnt[1:0], 3'b000} +: 8] <= byte_i;
            bcnt <= bcnt + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_i;
`endif
          end
        end
        S_WRITE: addr <= addr + ADDR_W'(4);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed sessions plus
// randomized payloads/gaps, checked against an array-based expected image.
module tb_instr_mem_loader;
  localparam int MEM = 4096;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          valid = 1'b0;
  logic          ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  int errors = 0;
  int checks = 0;
  logic [7:0]  pay[$];
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];

  instr_mem_loader #(.MEM_SIZE(MEM), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_i(byte_in),
    .byte_valid_i(valid), .byte_ready_o(ready), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // write monitor; ready must be low in any write cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_a.push_back(32'(wr_addr));
      obs_d.push_back(wr_data);
      chk("ready_in_write", 48'(ready), 48'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in = b;
    valid   = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (ready) break;
      if (n >= 50) begin
        checks++; errors++;
        $error("FAIL send_timeout: observed ready=0 expected ready=1 within 50 cycles");
        return;
      end
    end
    tick();
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
  endfunction

  function automatic logic [7:0] pay_xor(input int L);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < L; i++) x ^= pay[i];
    return x;
  endfunction

  task automatic chk_writes(input int nw);
    chk("nwrites", 48'(obs_a.size()), 48'(nw));
    for (int i = 0; i < nw && i < obs_a.size(); i++) begin
      chk($sformatf("waddr%0d", i), 48'(obs_a[i]), 48'(4*i));
      chk($sformatf("wdata%0d", i), 48'(obs_d[i]), 48'(exp_word(i)));
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 30; n++) begin
      if (!busy) return;
      tick();
    end
    checks++; errors++;
    $error("FAIL idle_timeout: observed busy=1 expected busy=0");
  endtask

  // full session: length header, payload (if length legal), checksum if built
  task automatic run(input logic [15:0] L, input int gapmax, input bit bad_csum,
                     input bit poke_start);
    bit ok, exp_done;
    int gap;
    obs_a.delete(); obs_d.delete();
    pulse_start();
    chk("start_clr", 48'({busy, done, err}), 48'(3'b100));
    send(L[7:0], 0);
    send(L[15:8], 0);
    ok = (L != 0) && (int'(L) <= MEM) && (L % 4 == 0);
    if (ok) begin
      for (int i = 0; i < int'(L); i++) begin
        gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
        if (poke_start && i == int'(L) / 2) start = 1'b1;
        send(pay[i], gap);
        start = 1'b0;
      end
    end
    exp_done = (L == 0) || ok;
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (exp_done) send(pay_xor(int'(L)) ^ (bad_csum ? 8'h5A : 8'h00), 0);
    if (bad_csum) exp_done = 1'b0;
`endif
    valid = 1'b0;
    wait_idle();
    chk("end_flags", 48'({busy, done, err}), 48'({1'b0, exp_done, ~exp_done}));
    chk_writes(ok ? int'(L) / 4 : 0);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    logic [15:0] L;
    int idx, cyc;
    bit acc;

    // reset state
    repeat (2) tick();
    chk("rst_ctl", 48'({ready, wr_en, busy, done, err}), 48'd0);
    chk("rst_addr", 48'(wr_addr), 48'd0);
    chk("rst_data", 48'(wr_data), 48'd0);
    rst = 1'b0;
    tick();

    // basic load with latency checks; valid held high throughout
    pay = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    obs_a.delete(); obs_d.delete();
    pulse_start();
    send(8'h08, 0); send(8'h00, 0);
    for (int i = 0; i < 4; i++) send(pay[i], 0);
    chk("b_wen0", 48'({wr_en, ready}), 48'(2'b10));
    chk("b_addr0", 48'(wr_addr), 48'h000);
    chk("b_data0", 48'(wr_data), 48'h00100513);
    for (int i = 4; i < 8; i++) send(pay[i], 0);
    chk("b_wen1", 48'(wr_en), 48'd1);
    chk("b_data1", 48'(wr_data), 48'h00200593);
    valid = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(pay_xor(8), 0);
    valid = 1'b0;
`endif
    tick();
    chk("b_flags", 48'({busy, done, err}), 48'(3'b010));
    chk_writes(2);

    // zero length
    run(16'h0000, 0, 1'b0, 1'b0);

    // bad lengths, then a good load clears err
    run(16'h0006, 0, 1'b0, 1'b0);
    run(16'h1004, 0, 1'b0, 1'b0);
    rand_pay(12);
    run(16'd12, 0, 1'b0, 1'b0);

    // back-pressure: valid toggling each cycle, L=4
    pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    obs_a.delete(); obs_d.delete();
    pulse_start();
    send(8'h04, 0); send(8'h00, 0);
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 100) begin
      byte_in = pay[idx];
      valid   = (cyc % 2 == 0);
      @(negedge clk);
      acc = valid && ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    valid = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(pay_xor(4), 0);
    valid = 1'b0;
`endif
    wait_idle();
    chk("bp_flags", 48'({busy, done, err}), 48'(3'b010));
    chk_writes(1);
    if (obs_d.size() > 0) chk("bp_word", 48'(obs_d[0]), 48'hDEADBEEF);

    // randomized loads with gaps; one ignores a start pulse mid-session
    for (int t = 0; t < 4; t++) begin
      L = 16'(4 * $urandom_range(1, 24));
      rand_pay(int'(L));
      run(L, 3, 1'b0, t == 1);
    end

    // full memory, incrementing words
    pay.delete();
    for (int i = 0; i < MEM / 4; i++)
      for (int k = 0; k < 4; k++) pay.push_back(8'(i >> (8 * k)));
    run(16'h1000, 0, 1'b0, 1'b0);
    if (obs_a.size() > 0) chk("full_last", 48'(obs_a[obs_a.size()-1]), 48'hFFC);

    // reset mid-session after two payload bytes
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulse_start();
    send(8'h08, 0); send(8'h00, 0);
    send(pay[0], 0); send(pay[1], 0);
    valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_ctl", 48'({ready, wr_en, busy, done, err}), 48'd0);
    chk("mrst_addr", 48'(wr_addr), 48'd0);
    chk("mrst_data", 48'(wr_data), 48'd0);
    rst = 1'b0;
    tick();
    rand_pay(16);
    run(16'd16, 2, 1'b0, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    rand_pay(8);
    run(16'd8, 0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
